// File: rtl/pln_pkg.sv
// Shared token, error-code and state definitions for the postfix front end
// (pln_fsm) and the evaluator (rpn_eval).
// Optional feature macro: RPN_DIV_EN makes '/' a legal operator token.
package pln_pkg;

    localparam logic [7:0] TOK_0     = 8'h30;
    localparam logic [7:0] TOK_9     = 8'h39;
    localparam logic [7:0] TOK_PLUS  = 8'h2B;
    localparam logic [7:0] TOK_MINUS = 8'h2D;
    localparam logic [7:0] TOK_STAR  = 8'h2A;
    localparam logic [7:0] TOK_SLASH = 8'h2F;
    localparam logic [7:0] TOK_EQ    = 8'h3D;
    localparam logic [7:0] TOK_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_UNDERFLOW = 3'd1,
        ERR_OVERFLOW  = 3'd2,
        ERR_ILLEGAL   = 3'd3,
        ERR_DIV_ZERO  = 3'd4,
        ERR_EQ_COUNT  = 3'd5
    } err_e;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        EXEC   = 2'd1,
        DONE   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // ASCII '0'..'9'
    function automatic logic is_digit(input logic [7:0] tok);
        return (tok >= TOK_0) && (tok <= TOK_9);
    endfunction

    // Binary operator tokens; '/' only when division is built in
    function automatic logic is_op(input logic [7:0] tok);
`ifdef RPN_DIV_EN
        return (tok == TOK_PLUS) || (tok == TOK_MINUS) || (tok == TOK_STAR) ||
               (tok == TOK_SLASH);
`else
        return (tok == TOK_PLUS) || (tok == TOK_MINUS) || (tok == TOK_STAR);
`endif
    endfunction

endpackage

// File: rtl/rpn_stack.sv
// DEPTH x WIDTH LIFO operand stack.
// Ports: push/push_data append an entry; replace/replace_data pops the top and
// overwrites the new top (entry count-2); clear empties the stack; top and
// second are combinational reads of the two uppermost entries; count is the
// number of valid entries. Storage itself is not reset.
module rpn_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     replace,
    input  logic [WIDTH-1:0]         replace_data,
    input  logic                     clear,
    output logic [WIDTH-1:0]         top,
    output logic [WIDTH-1:0]         second,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] sec_idx;

    // Indices wrap when the stack is shallow; callers only use them when valid
    assign top_idx = PTR_W'(count - CNT_W'(1));
    assign sec_idx = PTR_W'(count - CNT_W'(2));
    assign top     = mem[top_idx];
    assign second  = mem[sec_idx];

    // Storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem[count[PTR_W-1:0]] <= push_data;
        end else if (replace) begin
            mem[sec_idx] <= replace_data;
        end
    end

    // Entry counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push) begin
            count <= count + CNT_W'(1);
        end else if (replace) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/rpn_eval.sv
// Postfix (RPN) expression evaluator fed by an ASCII token stream.
// Ports: CLK clock; RST async active-low reset (released through a local
// synchroniser); IN_DAT/IN_VLD/IN_RDY token handshake; RES_DAT/RES_VLD/RES_RDY
// result handshake; ERR_VLD/ERR_CODE one-cycle error report.
// Optional feature macro: RPN_DIV_EN adds signed '/' (truncating toward zero).
module rpn_eval
    import pln_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       IN_DAT,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    output logic [WIDTH-1:0] RES_DAT,
    output logic             RES_VLD,
    input  logic             RES_RDY,
    output logic             ERR_VLD,
    output logic [2:0]       ERR_CODE
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]       rst_sync;
    logic             rst_n;
    state_e           state;
    state_e           state_nxt;
    logic             in_rdy;
    logic [7:0]       op;
    logic [WIDTH-1:0] res_dat;
    logic             res_vld;
    logic             err_vld;
    err_e             err_code;
    err_e             err_c;
    logic             accept_c;
    logic             push_c;
    logic             replace_c;
    logic             clear_c;
    logic             op_load_c;
    logic             load_res_c;
    logic             div_zero_c;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] second;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] alu_c;

    // Asynchronous assert, synchronous release
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    rpn_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk          (CLK),
        .rst_n        (rst_n),
        .push         (push_c),
        .push_data    (WIDTH'(IN_DAT - TOK_0)),
        .replace      (replace_c),
        .replace_data (alu_c),
        .clear        (clear_c),
        .top          (top),
        .second       (second),
        .count        (count)
    );

    // Operator datapath: a = second from top, b = top
`ifdef RPN_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    assign div_zero_c = (op == TOK_SLASH) && (top == '0);
`else
    assign div_zero_c = 1'b0;
`endif

    always_comb begin
        alu_c = '0;
        case (op)
            TOK_PLUS:  alu_c = second + top;
            TOK_MINUS: alu_c = second - top;
            TOK_STAR:  alu_c = second * top;
`ifdef RPN_DIV_EN
            // Most-negative / -1 wraps back to most-negative
            TOK_SLASH: alu_c = ((second == MIN_VAL) && (top == '1)) ? second :
                               WIDTH'($signed(second) / $signed(top));
`endif
            default:   alu_c = '0;
        endcase
    end

    assign accept_c = IN_VLD && in_rdy;

    // Next state, stack control and error decode
    always_comb begin
        state_nxt  = state;
        push_c     = 1'b0;
        replace_c  = 1'b0;
        clear_c    = 1'b0;
        op_load_c  = 1'b0;
        load_res_c = 1'b0;
        err_c      = ERR_NONE;
        case (state)
            ACCEPT: begin
                if (accept_c) begin
                    if (is_digit(IN_DAT)) begin
                        if (count == CNT_W'(DEPTH)) err_c = ERR_OVERFLOW;
                        else                        push_c = 1'b1;
                    end else if (is_op(IN_DAT)) begin
                        if (count < CNT_W'(2)) begin
                            err_c = ERR_UNDERFLOW;
                        end else begin
                            op_load_c = 1'b1;
                            state_nxt = EXEC;
                        end
                    end else if (IN_DAT == TOK_EQ) begin
                        if (count == CNT_W'(1)) begin
                            load_res_c = 1'b1;
                            state_nxt  = DONE;
                        end else begin
                            err_c = ERR_EQ_COUNT;
                        end
                    end else if (IN_DAT != TOK_SPACE) begin
                        err_c = ERR_ILLEGAL;
                    end
                    // An error on '=' already ends the expression
                    if (err_c != ERR_NONE) begin
                        clear_c   = 1'b1;
                        state_nxt = (IN_DAT == TOK_EQ) ? ACCEPT : DRAIN;
                    end
                end
            end
            EXEC: begin
                if (div_zero_c) begin
                    err_c     = ERR_DIV_ZERO;
                    clear_c   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    replace_c = 1'b1;
                    state_nxt = ACCEPT;
                end
            end
            DONE: begin
                if (RES_RDY) begin
                    clear_c   = 1'b1;
                    state_nxt = ACCEPT;
                end
            end
            DRAIN: begin
                if (accept_c && (IN_DAT == TOK_EQ)) state_nxt = ACCEPT;
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCEPT;
            in_rdy   <= 1'b0;
            op       <= '0;
            res_dat  <= '0;
            res_vld  <= 1'b0;
            err_vld  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            in_rdy   <= (state_nxt == ACCEPT) || (state_nxt == DRAIN);
            err_vld  <= (err_c != ERR_NONE);
            err_code <= err_c;
            if (op_load_c) op <= IN_DAT;
            if (load_res_c) begin
                res_dat <= top;
                res_vld <= 1'b1;
            end else if ((state == DONE) && RES_RDY) begin
                res_vld <= 1'b0;
            end
        end
    end

    assign IN_RDY   = in_rdy;
    assign RES_DAT  = res_dat;
    assign RES_VLD  = res_vld;
    assign ERR_VLD  = err_vld;
    assign ERR_CODE = err_code;

endmodule

// File: tb/tb_rpn_eval.sv
// Scoreboard bench for rpn_eval: the driver feeds tokens and a queue-based
// postfix model predicts each result or error; a monitor pops and compares
// whenever the DUT reports a result transfer or an error pulse.
module tb_rpn_eval;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
`ifdef RPN_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [7:0]       IN_DAT = 8'h20;
    logic             IN_VLD = 1'b0;
    logic             IN_RDY;
    logic [WIDTH-1:0] RES_DAT;
    logic             RES_VLD;
    logic             RES_RDY = 1'b0;
    logic             ERR_VLD;
    logic [2:0]       ERR_CODE;

    rpn_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DAT   (IN_DAT),
        .IN_VLD   (IN_VLD),
        .IN_RDY   (IN_RDY),
        .RES_DAT  (RES_DAT),
        .RES_VLD  (RES_VLD),
        .RES_RDY  (RES_RDY),
        .ERR_VLD  (ERR_VLD),
        .ERR_CODE (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_err;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   mst[$];
    bit   m_drain = 1'b0;
    bit   hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue used as the operand stack
    function automatic void m_err(input logic [7:0] t, input int code);
        sb.push_back('{1'b1, 32'(code)});
        mst.delete();
        m_drain = (t != "=");
    endfunction

    function automatic void model(input logic [7:0] t);
        int a;
        int b;
        int r;
        if (m_drain) begin
            if (t == "=") m_drain = 1'b0;
            return;
        end
        if (t >= "0" && t <= "9") begin
            if (mst.size() == DEPTH) m_err(t, 2);
            else mst.push_back(int'(t) - 48);
        end else if (t == "+" || t == "-" || t == "*" || (DIV_EN && t == "/")) begin
            if (mst.size() < 2) begin
                m_err(t, 1);
            end else begin
                b = mst.pop_back();
                a = mst.pop_back();
                if (t == "+")      r = a + b;
                else if (t == "-") r = a - b;
                else if (t == "*") r = a * b;
                else begin
                    if (b == 0) begin
                        m_err(t, 4);
                        return;
                    end
                    r = (a == int'(32'h80000000) && b == -1) ? a : a / b;
                end
                mst.push_back(r);
            end
        end else if (t == "=") begin
            if (mst.size() == 1) begin
                sb.push_back('{1'b0, 32'(mst[0])});
                mst.delete();
            end else begin
                m_err(t, 5);
            end
        end else if (t != " ") begin
            m_err(t, 3);
        end
    endfunction

    // Monitor: drives RES_RDY and checks every reported event
    always @(negedge CLK) begin
        exp_t e;
        RES_RDY = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (RST) begin
            if (ERR_VLD || RES_VLD) check("err_res_exclusive", 64'(ERR_VLD && RES_VLD), 64'd0);
            if (ERR_VLD) begin
                if (sb.size() == 0) begin
                    check("unexpected_err_event", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("err_kind", 64'(e.is_err), 64'd1);
                    check("err_code", 64'(ERR_CODE), 64'(e.val));
                end
            end
            if (RES_VLD && RES_RDY) begin
                if (sb.size() == 0) begin
                    check("unexpected_res_event", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("res_kind", 64'(e.is_err), 64'd0);
                    check("res_dat", 64'(RES_DAT), 64'(e.val));
                end
            end
        end
    end

    task automatic send(input logic [7:0] t);
        int n = 0;
        @(negedge CLK);
        IN_DAT = t;
        IN_VLD = 1'b1;
        while (!IN_RDY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_RDY) begin
            check("in_rdy_timeout", 64'(IN_RDY), 64'd1);
            IN_VLD = 1'b0;
            return;
        end
        @(posedge CLK);
        model(t);
        #1 IN_VLD = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_rdy", 64'(IN_RDY), 64'd0);
        check("rst_res_vld", 64'(RES_VLD), 64'd0);
        check("rst_res_dat", 64'(RES_DAT), 64'd0);
        check("rst_err_vld", 64'(ERR_VLD), 64'd0);
        check("rst_err_code", 64'(ERR_CODE), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops[3];
        string      noise;
        int         d;
        int         len;
        int         n;
        ops   = '{"+", "-", "*"};
        noise = "0123456789+-*/= a=#";

        repeat (3) @(negedge CLK);
        check_reset_outputs();
        RST = 1'b1;

        send_str("155*+=");
        send_str("35-=");
        send_str("+=");
        send_str("7=");
        for (int i = 0; i < 17; i++) send("1");
        send("=");
        send_str("12=");
        send_str("1a=");
        send_str("72/=");
        send_str("70/=");
        send_str("1 2 + =");
        wait_drain();

        // Result held while the consumer stalls
        hold = 1'b1;
        send_str("9=");
        n = 0;
        while (!RES_VLD && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("hold_vld_seen", 64'(RES_VLD), 64'd1);
        repeat (5) begin
            @(negedge CLK);
            check("hold_res_vld", 64'(RES_VLD), 64'd1);
            check("hold_res_dat", 64'(RES_DAT), 64'd9);
            check("hold_in_rdy", 64'(IN_RDY), 64'd0);
        end
        hold = 1'b0;
        wait_drain();

        // Reset in the middle of an expression
        send_str("15+");
        @(negedge CLK);
        RST = 1'b0;
        mst.delete();
        m_drain = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check_reset_outputs();
        end
        RST = 1'b1;
        send_str("4=");
        wait_drain();

        // Random well-formed expressions
        for (int e = 0; e < 40; e++) begin
            d   = 0;
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                if (d < 2 || (d < DEPTH && $urandom_range(0, 1) == 1)) begin
                    send(8'(8'h30 + $urandom_range(0, 9)));
                    d++;
                end else begin
                    send(ops[$urandom_range(0, 2)]);
                    d--;
                end
            end
            while (d > 1) begin
                send(ops[$urandom_range(0, 2)]);
                d--;
            end
            send("=");
        end

        // Random token noise including illegal characters
        for (int k = 0; k < 300; k++) begin
            send(noise[$urandom_range(0, noise.len() - 1)]);
        end
        send_str("=5=");
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
